// File: rtl/nap_alarm_scheduler.sv
// Power-nap alarm scheduler: counts a nap down on a divided one-second tick, then runs the alarm sequencer's start/stop.
// Optional NAP_PRE_ALARM_EN adds a pre_alarm output for the last PRE_SEC seconds of a countdown.
//
// state  | meaning
// IDLE   | nothing armed, waiting for set_pulse
// COUNT  | counting down the nap duration
// SNOOZE | counting down the snooze reload
// RING   | sequencer running, waiting for stop/snooze/timeout
module nap_alarm_scheduler #(
  parameter int CLK_DIV          = 50000000,
  parameter int NAP_W            = 16,
  parameter int SNOOZE_SEC       = 300,
  parameter int RING_TIMEOUT_SEC = 60,
  parameter int MAX_SNOOZE       = 3,
  parameter int PRE_SEC          = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             set_pulse,
  input  logic [NAP_W-1:0] nap_sec,
  input  logic             cancel,
  input  logic             stop_btn,
  input  logic             snooze_btn,
  output logic             alarm_start,
  output logic             alarm_stop,
  output logic             ringing,
  output logic             armed,
  output logic [NAP_W-1:0] remaining,
  output logic [2:0]       snooze_cnt
`ifdef NAP_PRE_ALARM_EN
  ,
  output logic             pre_alarm
`endif
);

  localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int RW = (RING_TIMEOUT_SEC > 1) ? $clog2(RING_TIMEOUT_SEC + 1) : 1;

  typedef enum logic [1:0] {IDLE, COUNT, SNOOZE, RING} state_t;

  state_t           state, state_nx;
  logic [PW-1:0]    presc;
  logic [RW-1:0]    ring_cnt, ring_nx;
  logic [NAP_W-1:0] rem_nx;
  logic [2:0]       snz_nx;
  logic             start_nx, stop_nx;
  logic             tick, snz_ok;

  assign tick   = (state != IDLE) && (presc == PW'(CLK_DIV - 1));
  assign snz_ok = snooze_cnt < 3'(MAX_SNOOZE);

  always_comb begin
    state_nx = state;
    rem_nx   = remaining;
    snz_nx   = snooze_cnt;
    ring_nx  = ring_cnt;
    start_nx = 1'b0;
    stop_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (set_pulse && (nap_sec != '0)) begin
          state_nx = COUNT;
          rem_nx   = nap_sec;
          snz_nx   = '0;
        end
      end
      COUNT, SNOOZE: begin
        if (cancel) begin
          state_nx = IDLE;
          rem_nx   = '0;
        end else if (tick) begin
          if (remaining == NAP_W'(1)) begin
            state_nx = RING;
            rem_nx   = '0;
            ring_nx  = '0;
            start_nx = 1'b1;
          end else if (remaining != '0) begin
            rem_nx = remaining - NAP_W'(1);
          end
        end
      end
      RING: begin
        // Decisions wait one cycle after entry so stop never follows start back-to-back.
        if (!alarm_start) begin
          if (stop_btn) begin
            state_nx = IDLE;
            stop_nx  = 1'b1;
          end else if (snooze_btn && snz_ok) begin
            state_nx = SNOOZE;
            rem_nx   = NAP_W'(SNOOZE_SEC);
            snz_nx   = snooze_cnt + 3'd1;
            stop_nx  = 1'b1;
          end else if (tick) begin
            if (ring_cnt == RW'(RING_TIMEOUT_SEC - 1)) begin
              stop_nx = 1'b1;
              if (snz_ok) begin
                state_nx = SNOOZE;
                rem_nx   = NAP_W'(SNOOZE_SEC);
                snz_nx   = snooze_cnt + 3'd1;
              end else begin
                state_nx = IDLE;
              end
            end else begin
              ring_nx = ring_cnt + RW'(1);
            end
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      presc       <= '0;
      ring_cnt    <= '0;
      remaining   <= '0;
      snooze_cnt  <= '0;
      alarm_start <= 1'b0;
      alarm_stop  <= 1'b0;
      ringing     <= 1'b0;
      armed       <= 1'b0;
    end else begin
      state       <= state_nx;
      ring_cnt    <= ring_nx;
      remaining   <= rem_nx;
      snooze_cnt  <= snz_nx;
      alarm_start <= start_nx;
      alarm_stop  <= stop_nx;
      ringing     <= (state_nx == RING);
      armed       <= (state_nx == COUNT) || (state_nx == SNOOZE);
      if ((state_nx != state) || tick) begin
        presc <= '0;
      end else if (state != IDLE) begin
        presc <= presc + PW'(1);
      end
    end
  end

`ifdef NAP_PRE_ALARM_EN
  logic pre_nx;
  assign pre_nx = ((state_nx == COUNT) || (state_nx == SNOOZE)) &&
                  (rem_nx != '0) && (int'(rem_nx) <= PRE_SEC);

  always_ff @(posedge clock) begin
    if (reset) begin
      pre_alarm <= 1'b0;
    end else begin
      pre_alarm <= pre_nx;
    end
  end
`endif

endmodule

// File: tb/tb_nap_alarm_scheduler.sv
// Self-checking bench for nap_alarm_scheduler: directed scenarios plus randomized traffic against an elapsed-time reference model.
module tb_nap_alarm_scheduler;

  localparam int CLK_DIV          = 4;
  localparam int NAP_W            = 16;
  localparam int SNOOZE_SEC       = 2;
  localparam int RING_TIMEOUT_SEC = 2;
  localparam int MAX_SNOOZE       = 2;
  localparam int PRE_SEC          = 2;

  localparam int P_IDLE = 0, P_COUNT = 1, P_SNOOZE = 2, P_RING = 3;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             set_pulse = 1'b0;
  logic [NAP_W-1:0] nap_sec = '0;
  logic             cancel = 1'b0;
  logic             stop_btn = 1'b0;
  logic             snooze_btn = 1'b0;
  logic             alarm_start, alarm_stop, ringing, armed;
  logic [NAP_W-1:0] remaining;
  logic [2:0]       snooze_cnt;
  logic             pre_bit;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: phase, cycles elapsed since phase entry, value loaded at entry.
  int m_phase = P_IDLE, m_el = 0, m_load = 0, exp_rem = 0, exp_snz = 0;
  bit exp_start = 1'b0, exp_stop = 1'b0;

  nap_alarm_scheduler #(
    .CLK_DIV(CLK_DIV), .NAP_W(NAP_W), .SNOOZE_SEC(SNOOZE_SEC),
    .RING_TIMEOUT_SEC(RING_TIMEOUT_SEC), .MAX_SNOOZE(MAX_SNOOZE), .PRE_SEC(PRE_SEC)
  ) dut (
    .clock(clock), .reset(reset), .set_pulse(set_pulse), .nap_sec(nap_sec),
    .cancel(cancel), .stop_btn(stop_btn), .snooze_btn(snooze_btn),
    .alarm_start(alarm_start), .alarm_stop(alarm_stop), .ringing(ringing),
    .armed(armed), .remaining(remaining), .snooze_cnt(snooze_cnt)
`ifdef NAP_PRE_ALARM_EN
    , .pre_alarm(pre_bit)
`endif
  );

`ifndef NAP_PRE_ALARM_EN
  assign pre_bit = 1'b0;
`endif

  always #5 clock = ~clock;

  function automatic logic [23:0] dut_vec();
    return {alarm_start, alarm_stop, ringing, armed, remaining, snooze_cnt, pre_bit};
  endfunction

  function automatic logic [23:0] model_vec();
    logic arm, pre;
    arm = (m_phase == P_COUNT) || (m_phase == P_SNOOZE);
    pre = 1'b0;
`ifdef NAP_PRE_ALARM_EN
    pre = arm && (exp_rem != 0) && (exp_rem <= PRE_SEC);
`endif
    return {exp_start, exp_stop, m_phase == P_RING, arm, 16'(exp_rem), 3'(exp_snz), pre};
  endfunction

  task automatic go_snooze();
    m_phase = P_SNOOZE;
    m_el    = 0;
    m_load  = SNOOZE_SEC;
    exp_rem = SNOOZE_SEC;
    exp_snz = exp_snz + 1;
    exp_stop = 1'b1;
  endtask

  task automatic model_step();
    bit tk, first, can_snz;
    int secs;
    exp_start = 1'b0;
    exp_stop  = 1'b0;
    tk      = ((m_el + 1) % CLK_DIV) == 0;
    secs    = (m_el + 1) / CLK_DIV;
    first   = (m_el == 0);
    can_snz = exp_snz < MAX_SNOOZE;
    m_el    = m_el + 1;
    if (reset) begin
      m_phase = P_IDLE; exp_rem = 0; exp_snz = 0; m_el = 0;
    end else begin
      case (m_phase)
        P_IDLE: if (set_pulse && nap_sec != 0) begin
          m_phase = P_COUNT; m_el = 0; m_load = int'(nap_sec); exp_rem = m_load; exp_snz = 0;
        end
        P_COUNT, P_SNOOZE: begin
          if (cancel) begin
            m_phase = P_IDLE; exp_rem = 0; m_el = 0;
          end else if (tk) begin
            exp_rem = m_load - secs;
            if (exp_rem == 0) begin
              m_phase = P_RING; m_el = 0; exp_start = 1'b1;
            end
          end
        end
        default: if (!first) begin
          if (stop_btn) begin
            m_phase = P_IDLE; m_el = 0; exp_stop = 1'b1;
          end else if (snooze_btn && can_snz) begin
            go_snooze();
          end else if (tk && secs >= RING_TIMEOUT_SEC) begin
            if (can_snz) go_snooze();
            else begin m_phase = P_IDLE; m_el = 0; exp_stop = 1'b1; end
          end
        end
      endcase
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic arm_nap(input int secs);
    set_pulse = 1'b1;
    nap_sec   = NAP_W'(secs);
    step();
    set_pulse = 1'b0;
  endtask

  task automatic wait_ring(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      step();
      ok = ringing;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    n_tests++;
    if (dut_vec() !== 24'h0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected %h", dut_vec(), 24'h0);
    end
    reset = 1'b0;
    step();
    n_tests++;
    if (dut_vec() !== model_vec()) begin
      n_fail++; $display("FAIL reset_idle: got %h expected %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_basic_nap();
    arm_nap(3);
    n_tests++;
    if (armed !== 1'b1 || remaining !== 16'd3) begin
      n_fail++; $display("FAIL basic_arm: armed=%b rem=%0d expected 1/3", armed, remaining);
    end
    for (int k = 1; k <= 12; k++) begin
      step();
      n_tests++;
      if (dut_vec() !== model_vec()) begin
        n_fail++; $display("FAIL basic_cycle%0d: got %h expected %h", k, dut_vec(), model_vec());
      end
      if (k == 4 || k == 8) begin
        n_tests++;
        if (remaining !== 16'((k == 4) ? 2 : 1)) begin
          n_fail++; $display("FAIL basic_rem_k%0d: got %0d expected %0d", k, remaining, (k == 4) ? 2 : 1);
        end
      end
    end
    n_tests++;
    if (alarm_start !== 1'b1 || ringing !== 1'b1) begin
      n_fail++; $display("FAIL basic_start: start=%b ringing=%b expected 1/1", alarm_start, ringing);
    end
    step();
    n_tests++;
    if (alarm_start !== 1'b0 || ringing !== 1'b1) begin
      n_fail++; $display("FAIL basic_start_once: start=%b ringing=%b expected 0/1", alarm_start, ringing);
    end
    stop_btn = 1'b1;
    step();
    stop_btn = 1'b0;
    n_tests++;
    if (alarm_stop !== 1'b1 || armed !== 1'b0 || ringing !== 1'b0) begin
      n_fail++; $display("FAIL basic_stop: stop=%b armed=%b ringing=%b expected 1/0/0", alarm_stop, armed, ringing);
    end
    step();
    n_tests++;
    if (alarm_stop !== 1'b0) begin
      n_fail++; $display("FAIL basic_stop_once: stop=%b expected 0", alarm_stop);
    end
  endtask

  task automatic test_snooze_limit();
    bit ok;
    arm_nap(1);
    for (int s = 1; s <= 3; s++) begin
      wait_ring(40, ok);
      n_tests++;
      if (!ok) begin
        n_fail++; $display("FAIL snooze_ring%0d: ringing=%b expected 1 within budget", s, ringing);
      end
      step();
      snooze_btn = 1'b1;
      step();
      snooze_btn = 1'b0;
      n_tests++;
      if (s < 3 && (snooze_cnt !== 3'(s) || remaining !== 16'd2 || alarm_stop !== 1'b1 || armed !== 1'b1)) begin
        n_fail++; $display("FAIL snooze_take%0d: cnt=%0d rem=%0d stop=%b armed=%b expected %0d/2/1/1",
                           s, snooze_cnt, remaining, alarm_stop, armed, s);
      end else if (s == 3 && (ringing !== 1'b1 || alarm_stop !== 1'b0 || snooze_cnt !== 3'd2)) begin
        n_fail++; $display("FAIL snooze_ignored: ringing=%b stop=%b cnt=%0d expected 1/0/2", ringing, alarm_stop, snooze_cnt);
      end
    end
    stop_btn = 1'b1;
    step();
    stop_btn = 1'b0;
    step();
  endtask

  task automatic test_ring_timeout();
    bit ok;
    int ring_cycles, stops;
    arm_nap(1);
    wait_ring(40, ok);
    ring_cycles = 0;
    while (!alarm_stop && ring_cycles < 50) begin
      step();
      ring_cycles++;
    end
    n_tests++;
    if (!ok || ring_cycles != 8 || armed !== 1'b1 || snooze_cnt !== 3'd1) begin
      n_fail++; $display("FAIL timeout_first: ring_cycles=%0d armed=%b cnt=%0d expected 8/1/1", ring_cycles, armed, snooze_cnt);
    end
    stops = 1;
    for (int i = 0; i < 200 && (armed || ringing); i++) begin
      step();
      if (alarm_stop) stops++;
      n_tests++;
      if (dut_vec() !== model_vec()) begin
        n_fail++; $display("FAIL timeout_track: got %h expected %h", dut_vec(), model_vec());
      end
    end
    step();
    n_tests++;
    if (stops != 3 || armed !== 1'b0 || ringing !== 1'b0 || alarm_stop !== 1'b0) begin
      n_fail++; $display("FAIL timeout_final: stops=%0d armed=%b ringing=%b expected 3/0/0", stops, armed, ringing);
    end
  endtask

  task automatic test_cancel_guards();
    bit seen_start;
    arm_nap(1);
    repeat (CLK_DIV - 1) step();
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    seen_start = alarm_start;
    repeat (10) begin
      step();
      seen_start = seen_start | alarm_start;
    end
    n_tests++;
    if (seen_start || armed !== 1'b0 || remaining !== '0 || ringing !== 1'b0) begin
      n_fail++; $display("FAIL cancel_expiry: start_seen=%b armed=%b rem=%0d expected 0/0/0", seen_start, armed, remaining);
    end
    arm_nap(0);
    n_tests++;
    if (armed !== 1'b0 || remaining !== '0) begin
      n_fail++; $display("FAIL zero_nap: armed=%b rem=%0d expected 0/0", armed, remaining);
    end
    arm_nap(5);
    step();
    arm_nap(9);
    n_tests++;
    if (remaining !== 16'd5 || armed !== 1'b1) begin
      n_fail++; $display("FAIL set_in_count: rem=%0d armed=%b expected 5/1", remaining, armed);
    end
    cancel = 1'b1;
    step();
    cancel = 1'b0;
  endtask

  task automatic test_simultaneous();
    bit ok;
    arm_nap(1);
    wait_ring(40, ok);
    step();
    stop_btn   = 1'b1;
    snooze_btn = 1'b1;
    step();
    stop_btn   = 1'b0;
    snooze_btn = 1'b0;
    n_tests++;
    if (!ok || ringing !== 1'b0 || armed !== 1'b0 || alarm_stop !== 1'b1 || snooze_cnt !== 3'd0) begin
      n_fail++; $display("FAIL stop_and_snooze: ringing=%b armed=%b stop=%b cnt=%0d expected 0/0/1/0",
                         ringing, armed, alarm_stop, snooze_cnt);
    end
    arm_nap(1);
    wait_ring(40, ok);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_tests++;
    if (!ok || dut_vec() !== 24'h0) begin
      n_fail++; $display("FAIL reset_in_ring: got %h expected %h", dut_vec(), 24'h0);
    end
  endtask

`ifdef NAP_PRE_ALARM_EN
  task automatic test_pre_alarm();
    arm_nap(4);
    for (int k = 1; k <= 16; k++) begin
      step();
      n_tests++;
      if ((k >= 8 && k < 16) !== pre_bit) begin
        n_fail++; $display("FAIL pre_alarm_k%0d: got %b expected %b", k, pre_bit, (k >= 8 && k < 16));
      end
    end
    stop_btn = 1'b1;
    step();
    step();
    stop_btn = 1'b0;
  endtask
`endif

  task automatic test_random();
    bit prev_pulse = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      set_pulse  = ($urandom_range(0, 7) == 0);
      nap_sec    = NAP_W'($urandom_range(0, 5));
      cancel     = ($urandom_range(0, 39) == 0);
      stop_btn   = ($urandom_range(0, 29) == 0);
      snooze_btn = ($urandom_range(0, 9) == 0);
      reset      = ($urandom_range(0, 499) == 0);
      step();
      n_tests++;
      if (dut_vec() !== model_vec()) begin
        n_fail++; $display("FAIL random_c%0d: got %h expected %h", c, dut_vec(), model_vec());
      end
      n_tests++;
      if ((alarm_start && alarm_stop) || (prev_pulse && (alarm_start || alarm_stop))) begin
        n_fail++; $display("FAIL pulse_spacing_c%0d: start=%b stop=%b prev=%b expected isolated pulses",
                           c, alarm_start, alarm_stop, prev_pulse);
      end
      prev_pulse = alarm_start | alarm_stop;
    end
    set_pulse = 1'b0; cancel = 1'b0; stop_btn = 1'b0; snooze_btn = 1'b0; reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_nap();
    test_snooze_limit();
    test_ring_timeout();
    test_cancel_guards();
    test_simultaneous();
`ifdef NAP_PRE_ALARM_EN
    test_pre_alarm();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nap_alarm_scheduler.md
Name: nap_alarm_scheduler

Overview:
- Schedules the buzzer/light alarm sequencer for the power-nap timer.
- Accepts a nap duration in seconds and counts it down on a divided one-second tick.
- Fires the sequencer's start input on expiry, then handles user stop, snooze and an unattended-ring timeout.
- Drives the sequencer's stop input whenever ringing must end.

Parameters:
- CLK_DIV, 50000000, clock cycles per one-second tick (≥2).
- NAP_W, 16, width of duration/remaining counters.
- SNOOZE_SEC, 300, reload value after snooze (1..2^NAP_W-1).
- RING_TIMEOUT_SEC, 60, seconds of unattended ringing before auto-snooze/stop (≥1).
- MAX_SNOOZE, 3, snoozes allowed per nap (0..7).
- PRE_SEC, 10, pre-alarm window in seconds; used only with the optional feature.

Ports:
- clock, input, 1, system clock.
- reset, input, 1, synchronous active-high reset.
- set_pulse, input, 1, one-cycle request to arm a nap.
- nap_sec, input, NAP_W, nap length in seconds; sampled on an accepted set_pulse.
- cancel, input, 1, abort the countdown (no ring).
- stop_btn, input, 1, user stop; level, sampled each cycle.
- snooze_btn, input, 1, user snooze; level, sampled each cycle.
- alarm_start, output, 1, one-cycle pulse to the sequencer's start.
- alarm_stop, output, 1, one-cycle pulse to the sequencer's stop.
- ringing, output, 1, high while in RING.
- armed, output, 1, high in COUNT or SNOOZE.
- remaining, output, NAP_W, seconds left in the current countdown.
- snooze_cnt, output, 3, snoozes consumed this nap.

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-high. It forces state IDLE and clears remaining, snooze_cnt, the prescaler and ring_cnt. All outputs are 0 after reset.
- Reset mid-ring: gives no alarm_stop pulse. The sequencer shares the reset.
- Registered outputs: all outputs are registered. Pulses appear in the cycle after the deciding edge.
- Prescaler: counts 0..CLK_DIV-1 only in COUNT, SNOOZE and RING. tick=1 for one cycle when it equals CLK_DIV-1, then wraps to 0. It clears to 0 on every state entry, so the first tick comes exactly CLK_DIV cycles after entry.
- IDLE:
  - set_pulse with nap_sec≠0 loads remaining=nap_sec, clears snooze_cnt and goes to COUNT.
  - set_pulse with nap_sec=0 is ignored.
- COUNT and SNOOZE:
  - remaining decrements on each tick.
  - A tick with remaining==1 sets remaining=0, goes to RING, pulses alarm_start and clears ring_cnt.
  - cancel goes to IDLE, clears remaining, and produces no pulses. cancel beats an expiry in the same cycle.
  - set_pulse is ignored outside IDLE.
- RING, priority stop > snooze > timeout:
  - stop_btn: go to IDLE and pulse alarm_stop.
  - snooze_btn with snooze_cnt<MAX_SNOOZE: go to SNOOZE, remaining=SNOOZE_SEC, snooze_cnt+1, pulse alarm_stop.
  - snooze_btn with snooze_cnt==MAX_SNOOZE: ignored; keep ringing.
  - ring_cnt increments on each tick. When it reaches RING_TIMEOUT_SEC, the block acts as snooze if allowed, otherwise as stop, with alarm_stop pulsed in both cases.
  - cancel has no effect in RING.
- Pulse spacing: alarm_start and alarm_stop are never high in the same cycle, and never high in back-to-back cycles. The sequencer samples start and stop every cycle, so one cycle is sufficient.
- Counter limits: remaining never underflows. snooze_cnt saturates at MAX_SNOOZE.

Optional Feature:
- Macro: NAP_PRE_ALARM_EN.
- Defined: adds output port pre_alarm (1 bit). It is high in COUNT or SNOOZE while remaining≤PRE_SEC and remaining≠0. It is low otherwise and low at reset.
- Not defined: the port and its logic are absent, and PRE_SEC is unused.
- Core behaviour is identical either way.

Test Plan:
- Basic nap: CLK_DIV=4, nap_sec=3 with set_pulse → armed=1 and remaining goes 3→2→1 at cycles 4/8 after arming. alarm_start pulses once at cycle 12, ringing=1. stop_btn → alarm_stop pulse, state IDLE, armed=0.
- Snooze limit: MAX_SNOOZE=2, SNOOZE_SEC=2 → snooze twice gives snooze_cnt=2 and remaining reloaded to 2 each time. The third snooze_btn is ignored and ringing stays 1.
- Ring timeout: RING_TIMEOUT_SEC=2 with no buttons → auto-snooze after 8 cycles of RING. Once snoozes are exhausted, timeout → IDLE with one alarm_stop pulse.
- Cancel and guards: cancel at remaining=1 in the tick cycle → IDLE, no alarm_start. nap_sec=0 set_pulse → stays IDLE. set_pulse during COUNT → remaining unchanged.
- Simultaneous inputs: stop_btn and snooze_btn both high in RING → IDLE, snooze_cnt unchanged. reset during RING → all outputs 0 next cycle.
- NAP_PRE_ALARM_EN with PRE_SEC=2, nap_sec=4 → pre_alarm rises when remaining=2 and falls on entering RING.
